uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1-class UART serializer that consumes the one-cycle baud_tick pulse from the shared baud generator and drives the serial tx line.
- Accepts bytes over a valid/ready handshake from the timestamp/packet formatter upstream.
- Supports back-to-back frames with no idle gap.
- Every bit boundary is aligned to baud_tick; the block contains no rate divider of its own.

Parameters:
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame, legal values 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- baud_tick  in  1  one-cycle pulse, one per bit period.
- in_data  in  DATA_BITS  byte to send.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data this cycle.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  frame in progress or byte pending.

Behaviour:
- Interface: single clock clk; rst_n is asynchronous, active-low.
- Reset values (async on rst_n low): state=IDLE, tx=1, busy=0, in_ready=1, bit counter=0, shift register=0.
- States: IDLE, ARMED, START, DATA, PARITY, STOP. tx drives 1 in IDLE and ARMED, 0 in START, shreg[0] in DATA, the parity bit in PARITY, 1 in STOP.
- Accept = in_valid & in_ready. On accept:
  - latch in_data into shreg;
  - compute parity: odd = ~^data, even = ^data;
  - clear bit counter.
- State changes happen only on cycles where baud_tick=1; tx updates in the cycle after that tick.
  - IDLE --accept--> ARMED (no tick needed). A tick coinciding with the accept cycle is ignored; the start bit waits for the next tick.
  - ARMED --tick--> START.
  - START --tick--> DATA.
  - DATA --tick--> shift shreg right, count+1. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY --tick--> STOP.
  - STOP --tick--> counts STOP_BITS periods. On the tick ending the last stop bit: if a byte was accepted during that last stop period, go to START; else go to IDLE.
- Every bit lasts exactly one tick-to-tick interval. Start-bit latency from accept is 1 to DIV+1 clocks, where DIV is the tick spacing.
- in_ready is combinational from state. It is 1 in IDLE, and 1 in STOP during the final stop bit provided no byte has been accepted there yet. It is 0 in every other state.
- Accepted data must not be overwritten. At most one pending byte exists, held in a separate hold register during STOP.
- busy = (state ≠ IDLE).
- in_valid with no ticks: the block stays in ARMED indefinitely with tx=1. There is no timeout.
- in_valid deasserting after accept has no effect; the frame completes.
- rst_n asserted mid-frame: tx=1 immediately (asynchronous). The frame is abandoned and the pending byte is dropped.
- Reset release is synchronized by the system reset block; this block needs no extra deassertion logic.
- X on in_data while in_valid=0 must not propagate to tx.

Decomposition:
- uart_pkg holds:
  - the uart_tx_state_e enum (IDLE, ARMED, START, DATA, PARITY, STOP);
  - parity encoding constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - a shared parity function reused by the future uart_rx.
- No sub-module; the serializer is a single FSM plus shift register and hold register.
- baud_tick is supplied externally so one generator can feed both tx and rx.

Test Plan:
- Bench drives baud_tick every 4 clocks, sends 0x55 with PARITY=0, STOP_BITS=1 → tx = 0,1,0,1,0,1,0,1,0,1, each level held exactly 4 clocks. busy falls in the cycle after the stop tick and in_ready=1.
- PARITY=2, send 0x07 → parity bit 1. PARITY=1, send 0x07 → parity bit 0. STOP_BITS=2 → tx high for 8 clocks after parity.
- in_valid held continuously with 0xA5 then 0x3C → second start bit directly follows the first stop bit, with no extra high period. Total 20 bit periods = 80 clocks.
- Accept 0x81 in the same cycle as baud_tick → that tick is ignored. Start bit appears after the next tick, 5 clocks after accept.
- Pull rst_n low during the 4th data bit of 0xFF → tx=1 in the same cycle without a clock edge. After release, state=IDLE, in_ready=1, and no residual frame is sent.
- in_valid=1 with 0x12 and baud_tick held 0 for 100 clocks → tx stays 1, busy=1, in_ready=0. The first tick starts the frame normally.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART serializer (and the future uart_rx).
//   uart_tx_state_e : serializer frame states
//   PAR_*           : encodings of the PARITY parameter
//   calc_parity()   : parity bit for a data word under a given parity mode
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Widest legal data word; narrower words are zero-extended before use,
  // which leaves the XOR reduction unchanged.
  localparam int MAX_DATA_BITS = 9;

  // Odd parity makes the total count of ones odd, even parity makes it even.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input int mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_ODD:  return ~p;
      PAR_EVEN: return p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART frame serializer driven by an external one-cycle baud_tick.
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   baud_tick in   one-cycle pulse per bit period
//   in_data   in   data word to send
//   in_valid  in   in_data is valid
//   in_ready  out  word can be accepted this cycle (combinational from state)
//   tx        out  serial line, idle high, registered
//   busy      out  frame in progress or word pending
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_tx_state_e       state, state_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [DATA_BITS-1:0] hold_data, hold_data_next;
  logic                 par_bit, par_bit_next;
  logic                 hold_par, hold_par_next;
  logic                 hold_valid, hold_valid_next;
  logic [3:0]           bit_cnt, bit_cnt_next;
  logic                 tx_next;
  logic                 last_stop;
  logic                 accept;
  logic                 in_par;

  // Handshake decode. A second word may only be taken during the final stop
  // bit, and only once, so the hold register can never be overwritten.
  always_comb begin
    last_stop = (state == ST_STOP) && (bit_cnt == LAST_STOP);
    in_ready  = (state == ST_IDLE) || (last_stop && !hold_valid);
    accept    = in_valid && in_ready;
    busy      = (state != ST_IDLE);
    in_par    = calc_parity(MAX_DATA_BITS'(in_data), PARITY);
  end

  // Next-state and datapath. Apart from the IDLE accept, nothing moves
  // except on a baud_tick, so every bit spans exactly one tick interval.
  always_comb begin
    state_next      = state;
    shreg_next      = shreg;
    par_bit_next    = par_bit;
    hold_data_next  = hold_data;
    hold_par_next   = hold_par;
    hold_valid_next = hold_valid;
    bit_cnt_next    = bit_cnt;

    case (state)
      // A tick coinciding with the accept is deliberately not used here;
      // the start bit always waits for the following tick.
      ST_IDLE: begin
        if (accept) begin
          state_next   = ST_ARMED;
          shreg_next   = in_data;
          par_bit_next = in_par;
          bit_cnt_next = '0;
        end
      end
      ST_ARMED: begin
        if (baud_tick) state_next = ST_START;
      end
      ST_START: begin
        if (baud_tick) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_next   = ST_STOP;
          bit_cnt_next = '0;
        end
      end
      // The counter keeps counting stop bits here, so an accept in this
      // state goes to the hold register and leaves the counter alone. A word
      // accepted on the closing tick itself goes straight into the shifter.
      ST_STOP: begin
        if (accept) begin
          hold_data_next  = in_data;
          hold_par_next   = in_par;
          hold_valid_next = 1'b1;
        end
        if (baud_tick) begin
          if (last_stop) begin
            bit_cnt_next = '0;
            if (hold_valid || accept) begin
              state_next      = ST_START;
              shreg_next      = hold_valid ? hold_data : in_data;
              par_bit_next    = hold_valid ? hold_par : in_par;
              hold_valid_next = 1'b0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The line level is derived from the next state so the registered tx
  // changes on the same edge as the state it belongs to.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shreg_next[0];
      ST_PARITY: tx_next = par_bit_next;
      default:   tx_next = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame and pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      par_bit    <= 1'b0;
      hold_data  <= '0;
      hold_par   <= 1'b0;
      hold_valid <= 1'b0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      par_bit    <= par_bit_next;
      hold_data  <= hold_data_next;
      hold_par   <= hold_par_next;
      hold_valid <= hold_valid_next;
      bit_cnt    <= bit_cnt_next;
      tx         <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Three instances cover the parity
// and stop-bit variants: dut0 (none,1), dut1 (odd,2), dut2 (even,1).
// baud_tick pulses once every 4 clocks; it is sampled on edges where cyc%4==1.
module tb_uart_tx;

  localparam int N = 3;
  localparam int PAR_CFG  [N] = '{0, 1, 2};
  localparam int STOP_CFG [N] = '{1, 2, 1};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         baud_tick;
  logic         tick_en;
  logic [7:0]   in_data;
  logic [N-1:0] vld;
  logic [N-1:0] rdy;
  logic [N-1:0] tx_vec;
  logic [N-1:0] busy_vec;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [7:0] exp_q [N][$];
  int last_start [N];
  int prev_start [N];
  int fall_edge  [N];
  int acc_edge   [N];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(vld[0]), .in_ready(rdy[0]), .tx(tx_vec[0]), .busy(busy_vec[0]));

  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(vld[1]), .in_ready(rdy[1]), .tx(tx_vec[1]), .busy(busy_vec[1]));

  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(vld[2]), .in_ready(rdy[2]), .tx(tx_vec[2]), .busy(busy_vec[2]));

  // Tick generator: high for the cycle that ends on an edge with cyc%4==1.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = tick_en && (cyc % 4 == 0);
    end
  end

  // Reference model: bits of a frame in line order.
  function automatic int frame_len(input int k);
    return 1 + 8 + ((PAR_CFG[k] != 0) ? 1 : 0) + STOP_CFG[k];
  endfunction

  function automatic logic exp_bit(input int k, input logic [7:0] d, input int b);
    int ones;
    ones = $countones(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR_CFG[k] != 0 && b == 9) begin
      if (PAR_CFG[k] == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: decodes each frame on tx[k], sampling every clock, and compares
  // each bit (4 samples) against the oldest queued word.
  task automatic mon(input int k);
    logic [7:0] d;
    logic       aborted;
    logic       expb;
    logic       actb;
    int         nb;
    forever begin
      @(negedge clk);
      if (rst_n && tx_vec[k] == 1'b0) begin
        prev_start[k] = last_start[k];
        last_start[k] = cyc;
        aborted = 1'b0;
        nb = frame_len(k);
        if (exp_q[k].size() == 0) begin
          checkOutput($sformatf("dut%0d_unexpected_frame", k), 32'd1, 32'd0);
          repeat (nb * 4 - 1) @(negedge clk);
        end else begin
          d = exp_q[k].pop_front();
          for (int b = 0; b < nb && !aborted; b++) begin
            expb = exp_bit(k, d, b);
            actb = expb;
            for (int s = 0; s < 4 && !aborted; s++) begin
              if (b != 0 || s != 0) @(negedge clk);
              if (!rst_n) aborted = 1'b1;
              else if (tx_vec[k] !== expb) actb = tx_vec[k];
            end
            if (!aborted)
              checkOutput($sformatf("dut%0d_byte%02h_bit%0d", k, d, b), 32'(actb), 32'(expb));
          end
        end
        while (!rst_n) @(negedge clk);
      end
    end
  endtask

  // Offers one word to all instances; each drops in_valid once it accepts.
  task automatic applyStimulus(input logic [7:0] b, input bit align);
    logic [N-1:0] pending;
    logic [N-1:0] acc;
    @(posedge clk);
    #1;
    if (align) begin
      for (int c = 0; c < 8 && (cyc % 4 != 0); c++) begin
        @(posedge clk);
        #1;
      end
    end
    pending = '1;
    in_data = b;
    vld     = pending;
    for (int c = 0; c < 400 && pending != 0; c++) begin
      @(negedge clk);
      acc = vld & rdy;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          exp_q[k].push_back(b);
          acc_edge[k] = cyc;
          pending[k] = 1'b0;
        end
      end
      vld = pending;
    end
    if (pending != 0) begin
      checkOutput($sformatf("accept_timeout_%02h", b), 32'(pending), 32'd0);
      pending = '0;
      vld = '0;
    end
    in_data = 8'hxx;
  endtask

  task automatic waitIdle();
    logic [N-1:0] seen;
    seen = '0;
    for (int c = 0; c < 2000 && seen != '1; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!seen[k] && !busy_vec[k]) begin
          seen[k] = 1'b1;
          fall_edge[k] = cyc;
        end
      end
    end
    if (seen != '1) checkOutput("idle_timeout", 32'(seen), 32'(3'b111));
  endtask

  task automatic sendAndTime(input logic [7:0] b, input bit align);
    applyStimulus(b, align);
    waitIdle();
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("dut%0d_frame_len_%02h", k, b),
                  32'(fall_edge[k] - last_start[k]), 32'(4 * frame_len(k)));
    checkOutput($sformatf("ready_after_%02h", b), 32'(rdy), 32'(3'b111));
    checkOutput($sformatf("tx_idle_after_%02h", b), 32'(tx_vec), 32'(3'b111));
  endtask

  initial begin
    int s_edge;
    logic [N-1:0] bad_tx;
    logic [N-1:0] bad_busy;
    logic [N-1:0] bad_rdy;
    int gap;

    rst_n   = 1'b0;
    vld     = '0;
    in_data = 8'hxx;
    tick_en = 1'b1;
    for (int k = 0; k < N; k++) begin
      last_start[k] = 0;
      prev_start[k] = 0;
      fall_edge[k]  = 0;
      acc_edge[k]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("dut%0d_reset_tx", k), 32'(tx_vec[k]), 32'd1);
      checkOutput($sformatf("dut%0d_reset_busy", k), 32'(busy_vec[k]), 32'd0);
      checkOutput($sformatf("dut%0d_reset_ready", k), 32'(rdy[k]), 32'd1);
    end
    rst_n = 1'b1;
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none

    $display("[TB] single frames");
    sendAndTime(8'h55, 1'b0);
    sendAndTime(8'h07, 1'b0);

    $display("[TB] back-to-back frames");
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h3C, 1'b0);
    waitIdle();
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("dut%0d_b2b_gap", k),
                  32'(last_start[k] - prev_start[k]), 32'(4 * frame_len(k)));
      checkOutput($sformatf("dut%0d_b2b_total", k),
                  32'(fall_edge[k] - prev_start[k]), 32'(8 * frame_len(k)));
    end

    // Accept lands on a tick edge; that tick is ignored, so tx drops on the
    // fourth edge after the accept edge (fifth clock counting the accept).
    $display("[TB] accept on tick");
    sendAndTime(8'h81, 1'b1);
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("dut%0d_start_latency", k),
                  32'(last_start[k] - acc_edge[k]), 32'd4);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hFF, 1'b1);
    s_edge = acc_edge[0] + 4;
    for (int c = 0; c < 200 && cyc < s_edge + 17; c++) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tx", 32'(tx_vec), 32'(3'b111));
    checkOutput("async_reset_busy", 32'(busy_vec), 32'd0);
    checkOutput("async_reset_ready", 32'(rdy), 32'(3'b111));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_busy", 32'(busy_vec), 32'd0);
    checkOutput("post_reset_ready", 32'(rdy), 32'(3'b111));
    bad_tx = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      bad_tx |= ~tx_vec | busy_vec;
    end
    checkOutput("no_residual_frame", 32'(bad_tx), 32'd0);

    $display("[TB] no ticks");
    @(posedge clk);
    #1;
    tick_en = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(8'h12, 1'b0);
    bad_tx = '0;
    bad_busy = '0;
    bad_rdy = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bad_tx   |= ~tx_vec;
      bad_busy |= ~busy_vec;
      bad_rdy  |= rdy;
    end
    checkOutput("notick_tx_high", 32'(bad_tx), 32'd0);
    checkOutput("notick_busy", 32'(bad_busy), 32'd0);
    checkOutput("notick_ready_low", 32'(bad_rdy), 32'd0);
    tick_en = 1'b1;
    waitIdle();
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("dut%0d_notick_frame_len", k),
                  32'(fall_edge[k] - last_start[k]), 32'(4 * frame_len(k)));

    $display("[TB] random words");
    for (int i = 0; i < 12; i++) begin
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      repeat (gap) @(posedge clk);
      applyStimulus(8'($urandom), 1'b0);
    end
    waitIdle();
    repeat (4) @(posedge clk);
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("dut%0d_queue_empty", k), 32'(exp_q[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
